// File: rtl/pipe_ctrl_v2_pkg.sv
// Shared encodings for the pipeline controller: opcodes, special instruction
// words, FSM states and control-bundle layouts.
package pipe_ctrl_v2_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_JMP   = 6'h02;

  localparam logic [31:0] NOP_WORD     = 32'h0000_0000;
  localparam logic [31:0] SYSCALL_WORD = 32'h0000_000C;
  localparam logic [31:0] HLT_WORD     = 32'hFFFF_FFFF;

  localparam int unsigned EX_W = 4;
  localparam int unsigned M_W  = 3;
  localparam int unsigned WB_W = 2;

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic [EX_W-1:0] ex;
    logic [M_W-1:0]  m;
    logic [WB_W-1:0] wb;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE  = '0;
  localparam ctrl_t CTRL_RTYPE = '{ex: 4'b1100, m: 3'b000, wb: 2'b10};
  localparam ctrl_t CTRL_LW    = '{ex: 4'b0001, m: 3'b010, wb: 2'b11};
  localparam ctrl_t CTRL_SW    = '{ex: 4'b0001, m: 3'b001, wb: 2'b00};
  localparam ctrl_t CTRL_BEQ   = '{ex: 4'b0010, m: 3'b100, wb: 2'b00};

endpackage

// File: rtl/pipe_ctrl_v2_if.sv
// ID-stage side of the pipeline controller; PIPE_CTRL_PERF_EN adds the
// stall/flush performance counters to the bundle.
import pipe_ctrl_v2_pkg::*;

interface pipe_ctrl_v2_if #(
  parameter int INST_W = 32,
  parameter int REG_AW = 5
);
  logic [INST_W-1:0] instr_id;
  logic              branch_taken;
  logic              ex_mem_read;
  logic [REG_AW-1:0] ex_rt;
  logic [EX_W-1:0]   ctrl_ex;
  logic [M_W-1:0]    ctrl_m;
  logic [WB_W-1:0]   ctrl_wb;
  logic              pc_write;
  logic              ifid_write;
  logic              if_flush;
  logic              id_flush;
  logic              ex_flush;
  logic              done;
`ifdef PIPE_CTRL_PERF_EN
  logic [15:0]       stall_cnt;
  logic [15:0]       flush_cnt;

  modport master (
    output instr_id, branch_taken, ex_mem_read, ex_rt,
    input  ctrl_ex, ctrl_m, ctrl_wb, pc_write, ifid_write,
    input  if_flush, id_flush, ex_flush, done, stall_cnt, flush_cnt
  );
  modport slave (
    input  instr_id, branch_taken, ex_mem_read, ex_rt,
    output ctrl_ex, ctrl_m, ctrl_wb, pc_write, ifid_write,
    output if_flush, id_flush, ex_flush, done, stall_cnt, flush_cnt
  );
`else
  modport master (
    output instr_id, branch_taken, ex_mem_read, ex_rt,
    input  ctrl_ex, ctrl_m, ctrl_wb, pc_write, ifid_write,
    input  if_flush, id_flush, ex_flush, done
  );
  modport slave (
    input  instr_id, branch_taken, ex_mem_read, ex_rt,
    output ctrl_ex, ctrl_m, ctrl_wb, pc_write, ifid_write,
    output if_flush, id_flush, ex_flush, done
  );
`endif
endinterface

// File: rtl/pipe_hazard_unit.sv
// Combinational load-use detector: flags an ID instruction that reads the
// register a load currently in EX is about to write.
import pipe_ctrl_v2_pkg::*;

module pipe_hazard_unit #(
  parameter int INST_W = 32,
  parameter int REG_AW = 5
) (
  input  logic [INST_W-1:0] instr_id,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rt,
  output logic              hazard
);
  logic [5:0]        opcode;
  logic [REG_AW-1:0] rs;
  logic [REG_AW-1:0] rt;
  logic              reads_rt;
  logic              unused_low;

  assign opcode     = instr_id[INST_W-1 -: 6];
  assign rs         = instr_id[INST_W-7 -: REG_AW];
  assign rt         = instr_id[INST_W-7-REG_AW -: REG_AW];
  assign unused_low = ^instr_id[INST_W-7-2*REG_AW:0];

  // Only these formats actually source rt; for LW it is the destination.
  assign reads_rt = (opcode == OP_RTYPE) || (opcode == OP_SW) || (opcode == OP_BEQ);

  assign hazard = ex_mem_read && (ex_rt != '0) &&
                  ((ex_rt == rs) || ((ex_rt == rt) && reads_rt));

endmodule

// File: rtl/pipe_ctrl_v2.sv
// Single-issue pipeline controller: ID decode, load-use stall, branch/jump
// flush and HLT drain. Define PIPE_CTRL_PERF_EN for stall/flush counters.
import pipe_ctrl_v2_pkg::*;

module pipe_ctrl_v2 #(
  parameter int INST_W       = 32,
  parameter int REG_AW       = 5,
  parameter int DRAIN_CYCLES = 3
) (
  input logic           clk,
  input logic           rst,
  pipe_ctrl_v2_if.slave bus
);
  state_t      state, state_next;
  logic [3:0]  drain_cnt, drain_cnt_next;
  logic        hazard;
  logic [5:0]  opcode;
  ctrl_t       decoded;
  ctrl_t       ctrl;
  logic        is_hlt;

  pipe_hazard_unit #(
    .INST_W(INST_W),
    .REG_AW(REG_AW)
  ) u_hazard (
    .instr_id   (bus.instr_id),
    .ex_mem_read(bus.ex_mem_read),
    .ex_rt      (bus.ex_rt),
    .hazard     (hazard)
  );

  assign opcode = bus.instr_id[INST_W-1 -: 6];
  assign is_hlt = (bus.instr_id == INST_W'(HLT_WORD));

  always_comb begin
    decoded = CTRL_NONE;
    case (opcode)
      OP_RTYPE: begin
        if ((bus.instr_id != INST_W'(NOP_WORD)) && (bus.instr_id != INST_W'(SYSCALL_WORD)))
          decoded = CTRL_RTYPE;
      end
      OP_LW:   decoded = CTRL_LW;
      OP_SW:   decoded = CTRL_SW;
      OP_BEQ:  decoded = CTRL_BEQ;
      default: decoded = CTRL_NONE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_RESET;
      drain_cnt <= '0;
    end else begin
      state     <= state_next;
      drain_cnt <= drain_cnt_next;
    end
  end

  always_comb begin
    state_next      = state;
    drain_cnt_next  = drain_cnt;
    ctrl            = CTRL_NONE;
    bus.pc_write    = 1'b0;
    bus.ifid_write  = 1'b0;
    bus.if_flush    = 1'b0;
    bus.id_flush    = 1'b0;
    bus.ex_flush    = 1'b0;
    bus.done        = 1'b0;
    case (state)
      ST_RUN: begin
        if (hazard) begin
          bus.id_flush = 1'b1;
        end else begin
          bus.pc_write   = 1'b1;
          bus.ifid_write = 1'b1;
          ctrl           = decoded;
          bus.if_flush   = ((opcode == OP_BEQ) && bus.branch_taken) || (opcode == OP_JMP);
          if (is_hlt) begin
            drain_cnt_next = 4'(DRAIN_CYCLES - 1);
            state_next     = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        // EX/MEM is left running so instructions already past ID retire.
        bus.if_flush = 1'b1;
        bus.id_flush = 1'b1;
        if (drain_cnt == '0) state_next = ST_DONE;
        else                 drain_cnt_next = drain_cnt - 4'd1;
      end
      ST_DONE: begin
        bus.if_flush = 1'b1;
        bus.id_flush = 1'b1;
        bus.ex_flush = 1'b1;
        bus.done     = 1'b1;
      end
      default: begin
        bus.if_flush = 1'b1;
        bus.id_flush = 1'b1;
        bus.ex_flush = 1'b1;
        state_next   = (state == ST_RESET) ? ST_RUN : ST_RESET;
      end
    endcase
  end

  assign bus.ctrl_ex = ctrl.ex;
  assign bus.ctrl_m  = ctrl.m;
  assign bus.ctrl_wb = ctrl.wb;

`ifdef PIPE_CTRL_PERF_EN
  logic [15:0] stall_cnt, flush_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (state == ST_RUN) begin
      if (hazard && (stall_cnt != '1))       stall_cnt <= stall_cnt + 16'd1;
      if (bus.if_flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + 16'd1;
    end
  end

  assign bus.stall_cnt = stall_cnt;
  assign bus.flush_cnt = flush_cnt;
`endif

endmodule

// File: tb/tb_pipe_ctrl_v2.sv
// Directed bench for pipe_ctrl_v2: decode, load-use stall, flushes, HLT drain
// and mid-drain reset, with hand-computed expected output vectors.
module tb_pipe_ctrl_v2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  pipe_ctrl_v2_if #(.INST_W(32), .REG_AW(5)) bus ();

  pipe_ctrl_v2 #(.INST_W(32), .REG_AW(5), .DRAIN_CYCLES(3)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  // Vector layout: ex[4] m[3] wb[2] | pc_write ifid_write if_flush id_flush ex_flush done
  localparam logic [14:0] E_RST   = {9'b0000_000_00, 6'b001110};
  localparam logic [14:0] E_STALL = {9'b0000_000_00, 6'b000100};
  localparam logic [14:0] E_LW    = {9'b0001_010_11, 6'b110000};
  localparam logic [14:0] E_R     = {9'b1100_000_10, 6'b110000};
  localparam logic [14:0] E_SW    = {9'b0001_001_00, 6'b110000};
  localparam logic [14:0] E_BEQT  = {9'b0010_100_00, 6'b111000};
  localparam logic [14:0] E_BEQN  = {9'b0010_100_00, 6'b110000};
  localparam logic [14:0] E_JMP   = {9'b0000_000_00, 6'b111000};
  localparam logic [14:0] E_ZERO  = {9'b0000_000_00, 6'b110000};
  localparam logic [14:0] E_DRAIN = {9'b0000_000_00, 6'b001100};
  localparam logic [14:0] E_DONE  = {9'b0000_000_00, 6'b001111};

  localparam logic [31:0] I_LW     = 32'h8C00_0000;
  localparam logic [31:0] I_LW_RS5 = 32'h8CA1_0000;
  localparam logic [31:0] I_LW_RT5 = 32'h8C25_0000;
  localparam logic [31:0] I_R_RT5  = 32'h0025_0020;
  localparam logic [31:0] I_SW_RT5 = 32'hAC25_0000;
  localparam logic [31:0] I_BEQ    = 32'h1043_0000;
  localparam logic [31:0] I_JMP    = 32'h0800_0010;
  localparam logic [31:0] I_NOP    = 32'h0000_0000;
  localparam logic [31:0] I_SYS    = 32'h0000_000C;
  localparam logic [31:0] I_HLT    = 32'hFFFF_FFFF;

  task automatic cyc(input logic [31:0] ins, input logic bt, input logic mr, input logic [4:0] rt);
    @(negedge clk);
    bus.instr_id     = ins;
    bus.branch_taken = bt;
    bus.ex_mem_read  = mr;
    bus.ex_rt        = rt;
    #1;
  endtask

  task automatic chk(input string tag, input logic [14:0] exp);
    logic [14:0] obs;
    obs = {bus.ctrl_ex, bus.ctrl_m, bus.ctrl_wb, bus.pc_write, bus.ifid_write,
           bus.if_flush, bus.id_flush, bus.ex_flush, bus.done};
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    bus.instr_id     = '0;
    bus.branch_taken = 1'b0;
    bus.ex_mem_read  = 1'b0;
    bus.ex_rt        = '0;

    // Reset state and first decode
    cyc(I_LW, 0, 0, 0);  chk("reset_held", E_RST);
    #1 rst = 1'b0; #1;   chk("reset_cycle0", E_RST);
    cyc(I_LW, 0, 0, 0);  chk("lw_decode", E_LW);

    // Load-use hazards
    cyc(I_R_RT5, 0, 1, 5'd5);  chk("rtype_rt_stall", E_STALL);
    cyc(I_R_RT5, 0, 1, 5'd0);  chk("ex_rt0_nostall", E_R);
    cyc(I_R_RT5, 0, 0, 5'd5);  chk("no_memread", E_R);
    cyc(I_LW_RS5, 0, 1, 5'd5); chk("lw_rs_stall", E_STALL);
    cyc(I_LW_RT5, 0, 1, 5'd5); chk("lw_rt_nostall", E_LW);
    cyc(I_SW_RT5, 0, 1, 5'd5); chk("sw_rt_stall", E_STALL);
    cyc(I_SW_RT5, 0, 0, 5'd5); chk("sw_decode", E_SW);

    // Branch / jump
    cyc(I_BEQ, 1, 0, 0);     chk("beq_taken", E_BEQT);
    cyc(I_BEQ, 0, 0, 0);     chk("beq_not_taken", E_BEQN);
    cyc(I_BEQ, 1, 1, 5'd3);  chk("beq_taken_hazard", E_STALL);
    cyc(I_JMP, 0, 0, 0);     chk("jmp", E_JMP);
    cyc(I_NOP, 0, 0, 0);     chk("nop", E_ZERO);
    cyc(I_SYS, 0, 0, 0);     chk("syscall", E_ZERO);

    // HLT is ignored while stalled, then drains exactly three cycles
    cyc(I_HLT, 0, 1, 5'd31); chk("hlt_hazard", E_STALL);
    cyc(I_HLT, 0, 0, 0);     chk("hlt_accept", E_ZERO);
    for (int i = 0; i < 3; i++) begin
      cyc(I_LW, 1, 0, 0);    chk("drain", E_DRAIN);
    end
    for (int i = 0; i < 20; i++) begin
      cyc(I_JMP, 0, 0, 0);   chk("done_hold", E_DONE);
    end

    // Reset pulse mid-drain
    @(negedge clk); rst = 1'b1; #1; chk("reset_again", E_RST); #1 rst = 1'b0;
    cyc(I_HLT, 0, 0, 0);     chk("hlt_accept2", E_ZERO);
    cyc(I_NOP, 0, 0, 0);     chk("drain1", E_DRAIN);
    cyc(I_NOP, 0, 0, 0);     chk("drain2", E_DRAIN);
    #1 rst = 1'b1; #1;       chk("async_reset_in_drain", E_RST);
    #1 rst = 1'b0;
    cyc(I_NOP, 0, 0, 0);     chk("run_after_reset", E_ZERO);
    for (int i = 0; i < 8; i++) begin
      cyc(I_NOP, 0, 0, 0);   chk("no_done_after_reset", E_ZERO);
    end

    // Fresh HLT after the interrupted one still drains the full three cycles
    cyc(I_HLT, 0, 0, 0);     chk("hlt_accept3", E_ZERO);
    for (int i = 0; i < 3; i++) begin
      cyc(I_NOP, 0, 0, 0);   chk("drain_reload", E_DRAIN);
    end
    cyc(I_NOP, 0, 0, 0);     chk("done_after_reload", E_DONE);

`ifdef PIPE_CTRL_PERF_EN
    @(negedge clk); rst = 1'b1; #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc(I_R_RT5, 0, 1, 5'd5); chk("perf_stall", E_STALL);
    end
    cyc(I_JMP, 0, 0, 0);     chk("perf_jmp", E_JMP);
    cyc(I_NOP, 0, 0, 0);
    total++;
    assert (bus.stall_cnt === 16'd4) else begin
      bad++;
      $error("FAIL stall_cnt observed=%0d expected=4", bus.stall_cnt);
    end
    total++;
    assert (bus.flush_cnt === 16'd1) else begin
      bad++;
      $error("FAIL flush_cnt observed=%0d expected=1", bus.flush_cnt);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl_v2.md
Name: pipe_ctrl_v2

Overview:
Parametrised successor to the single-issue pipeline controller.
- Decodes the ID-stage instruction into EX/M/WB control bundles.
- Detects load-use hazards and stalls the front end; flushes on taken BEQ and on JMP.
- On HLT, drains the back end for a programmable number of cycles before asserting done.
- Sits beside the ID stage; drives PC/IF-ID write enables and the per-stage flush lines.

Parameters:
INST_W, 32, instruction width; opcode in [INST_W-1:INST_W-6].
REG_AW, 5, register-address width; rs=[25:21], rt=[20:16] for the default widths.
DRAIN_CYCLES, 3, cycles spent in DRAIN after HLT (legal range 1..15).

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
instr_id  in  INST_W  instruction currently in ID
branch_taken  in  1  BEQ comparison result from ID
ex_mem_read  in  1  instruction in EX is a load
ex_rt  in  REG_AW  destination register of the load in EX
ctrl_ex  out  4  EX control bundle
ctrl_m  out  3  M control bundle
ctrl_wb  out  2  WB control bundle
pc_write  out  1  PC update enable
ifid_write  out  1  IF/ID register enable
if_flush  out  1  flush IF/ID
id_flush  out  1  insert bubble into ID/EX
ex_flush  out  1  flush EX/MEM
done  out  1  program finished (sticky until reset)

Behaviour:
Encodings, held in the shared package:
- Opcodes: RTYPE=6'h00, LW=6'h23, SW=6'h2B, BEQ=6'h04, JMP=6'h02.
- Full words: NOP=32'h0000_0000, SYSCALL=32'h0000_000C, HLT=32'hFFFF_FFFF.

Decode (ctrl_ex/ctrl_m/ctrl_wb):
- RTYPE other than NOP/SYSCALL: 1100/000/10.
- LW: 0001/010/11.
- SW: 0001/001/00.
- BEQ: 0010/100/00.
- All others, including NOP, SYSCALL, JMP and HLT: all zero.

State machine: 2-bit register, async reset to RESET. All outputs are combinational from state and inputs.
- RESET: all control bundles 0; if/id/ex_flush=1; pc_write=ifid_write=0; done=0. Always goes to RUN next cycle.
- RUN:
  - Hazard: ex_mem_read && ex_rt!=0 && (ex_rt==rs || (ex_rt==rt && opcode in {RTYPE,SW,BEQ})).
  - On hazard: pc_write=ifid_write=0, id_flush=1, control bundles forced to 0, if_flush=0. branch_taken and HLT are ignored that cycle.
  - No hazard: pc_write=ifid_write=1, id_flush=0, ex_flush=0, bundles from decode.
  - if_flush=1 when (opcode==BEQ && branch_taken) or opcode==JMP.
  - instr_id==HLT and no hazard: load drain counter with DRAIN_CYCLES-1, go to DRAIN.
- DRAIN: pc_write=ifid_write=0; if_flush=id_flush=1; ex_flush=0 so in-flight EX/MEM/WB complete. Bundles 0. Counter decrements each cycle; when it reaches 0, go to DONE. Total cycles spent in DRAIN = DRAIN_CYCLES.
- DONE: done=1; all flushes 1; enables 0; bundles 0. Remains in DONE until rst.
- Illegal state code: behaves as RESET and goes to RESET next cycle.
- rst asserted mid-operation (any state, including DRAIN): immediate return to RESET; drain counter cleared to 0.

Optional Feature:
Macro PIPE_CTRL_PERF_EN.
- Defined: adds outputs stall_cnt[15:0] and flush_cnt[15:0].
  - stall_cnt increments each RUN cycle with a hazard.
  - flush_cnt increments each RUN cycle with if_flush=1.
  - Both saturate at 16'hFFFF, async-clear on rst, and freeze outside RUN.
- Undefined: the ports and counters do not exist; no other behaviour changes.

Decomposition:
- Shared package/def file holds: opcode constants, NOP/SYSCALL/HLT words, state encodings (RESET=0, RUN=1, DRAIN=2, DONE=3), bundle-width constants.
- One sub-module, pipe_hazard_unit: purely combinational load-use detector. Inputs instr_id, ex_mem_read, ex_rt; output hazard.
- FSM, drain counter and decode stay in pipe_ctrl_v2.

Test Plan:
1. Reset, then instr_id=LW (opcode 23), no hazard -> cycle 0: all flushes 1, done 0; cycle 1: ctrl_ex=0001, ctrl_m=010, ctrl_wb=11, pc_write=1.
2. ex_mem_read=1, ex_rt=5; ID holds an RTYPE with rt=5 -> pc_write=0, ifid_write=0, id_flush=1, bundles 0. Repeat with ex_rt=0 -> no stall.
3. BEQ with branch_taken=1 -> if_flush=1, ctrl_m=100. Same BEQ during a hazard -> if_flush=0, stall asserted.
4. JMP -> if_flush=1 and bundles all 0.
5. HLT with DRAIN_CYCLES=3 -> exactly 3 DRAIN cycles (ex_flush=0, if_flush=1), then done=1 held for 20 further cycles.
6. rst pulsed during the 2nd DRAIN cycle -> immediate RESET outputs, RUN on the next cycle, done never asserted.
   With PIPE_CTRL_PERF_EN defined: 4 hazard cycles -> stall_cnt=4.
